pattern_scan_ctrl: RTL and testbench

Run controller for serial pattern detection: holds a programmable pattern of 1 to PAT_W bits and scans a qualified serial bit stream for it. Each run is started, bounded and terminated by the controller, which counts matches. It sits between the host/config logic and the serial data input and generalises the fixed 3-bit "101" detector. It sequences arming, match counting, target/window termination and completion handshake.

---
 rtl/pattern_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: scans a qualified serial stream for a programmable 1..PAT_W-bit pattern, counting matches per run with target/window termination
module pattern_scan_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             done_ack,
  input  logic             datain,
  input  logic             din_valid,
  output logic             pattern_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, hist_n, mask;
  logic [LEN_W-1:0] len_q, len_d, seen_q, seen_d, seen_inc;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
  logic [WIN_W-1:0] win_q, win_d, wcnt_q, wcnt_d, wcnt_inc;
  logic ovl_q, ovl_d, det_q, det_d, to_q, to_d, err_q, err_d, hit, tgt_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_W'(3'b101);
      len_q   <= LEN_W'(3);
      ovl_q   <= 1'b1;
      tgt_q   <= '0;
      win_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      win_q   <= win_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    tgt_d    = tgt_q;
    win_d    = win_q;
    hist_d   = hist_q;
    seen_d   = seen_q;
    wcnt_d   = wcnt_q;
    cnt_d    = cnt_q;
    det_d    = 1'b0;
    to_d     = to_q;
    err_d    = err_q;
    mask     = ~({PAT_W{1'b1}} << len_q);
    hist_n   = {hist_q[PAT_W-2:0], datain};
    seen_inc = (seen_q >= len_q) ? len_q : seen_q + 1'b1;
    hit      = (seen_inc >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
    cnt_inc  = cnt_q + CNT_W'(cnt_q != '1);
    tgt_hit  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
    wcnt_inc = wcnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ovl_d = cfg_overlap;
          tgt_d = cfg_target;
          win_d = cfg_window;
        end
        if (start) begin
          hist_d  = '0;
          seen_d  = '0;
          wcnt_d  = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
          err_d   = (len_d == '0) || (len_d > LEN_W'(PAT_W));
          state_d = err_d ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (abort) state_d = IDLE;
        else if (din_valid) begin
          hist_d = hist_n;
          wcnt_d = wcnt_inc;
          seen_d = (hit && !ovl_q) ? '0 : seen_inc;
          det_d  = hit;
          cnt_d  = hit ? cnt_inc : cnt_q;
          if (tgt_hit || ((win_q != '0) && (wcnt_inc == win_q))) begin
            state_d = DONE;
            to_d    = !tgt_hit;
          end
        end
      end
      DONE: state_d = (done_ack || abort) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign cfg_ready        = state_q == IDLE;
  assign busy             = state_q == SCAN;
  assign done             = state_q == DONE;
  assign pattern_detected = det_q;
  assign match_count      = cnt_q;
  assign timeout          = to_q;
  assign err              = err_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and random stimulus checked against a bit-queue reference model
module tb_pattern_scan_ctrl;
  logic clk = 0;
  logic rst = 1, cfg_valid = 0, cfg_overlap = 0, start = 0, abort = 0, done_ack = 0, datain = 0, din_valid = 0;
  logic [7:0] cfg_pattern = 0, cfg_target = 0;
  logic [3:0] cfg_len = 0;
  logic [15:0] cfg_window = 0;
  logic cfg_ready, pattern_detected, busy, done, timeout, err;
  logic [7:0] match_count;
  int n_chk = 0, n_bad = 0;
  int m_st, m_cnt, m_len, m_tgt, m_win, m_base;
  bit m_det, m_to, m_err, m_ovl;
  logic [7:0] m_pat;
  bit mq[$];
  always #5 clk = ~clk;
  pattern_scan_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_window(cfg_window), .start(start), .abort(abort),
    .done_ack(done_ack), .datain(datain), .din_valid(din_valid),
    .pattern_detected(pattern_detected), .match_count(match_count), .busy(busy),
    .done(done), .timeout(timeout), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model();
    int n;
    bit ok;
    m_det = 0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_to = 0; m_err = 0;
      m_pat = 8'b101; m_len = 3; m_ovl = 1; m_tgt = 0; m_win = 0;
    end else if (m_st == 0) begin
      if (cfg_valid) begin
        m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_tgt = cfg_target; m_win = cfg_window;
      end
      if (start) begin
        mq.delete(); m_base = 0; m_cnt = 0; m_to = 0;
        m_err = !(m_len >= 1 && m_len <= 8);
        m_st = m_err ? 2 : 1;
      end
    end else if (m_st == 1) begin
      if (abort) m_st = 0;
      else if (din_valid) begin
        mq.push_back(datain);
        n = mq.size();
        ok = (n - m_base >= m_len);
        for (int i = 0; i < m_len && ok; i++) if (mq[n-1-i] != m_pat[i]) ok = 0;
        if (ok) begin
          m_det = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) m_base = n;
        end
        if (ok && m_tgt != 0 && m_cnt == m_tgt) begin m_st = 2; m_to = 0; end
        else if (m_win != 0 && n == m_win) begin m_st = 2; m_to = 1; end
      end
    end else if (done_ack || abort) m_st = 0;
  endtask
  task automatic tick();
    model();
    @(posedge clk); #1;
    chk("det", pattern_detected, m_det);
    chk("count", match_count, m_cnt);
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("ready", cfg_ready, m_st == 0);
    chk("timeout", timeout, m_to);
    chk("err", err, m_err);
    {rst, cfg_valid, start, abort, done_ack, din_valid} = '0;
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t, input logic [15:0] w, input logic s);
    cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_window = w; start = s;
    tick();
  endtask
  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din_valid = 1; datain = v[i];
      tick();
    end
  endtask
  task automatic pulse_start();
    start = 1; tick();
  endtask
  initial begin
    tick();
    pulse_start(); bits(32'b10101, 5); tick();
    abort = 1; tick();
    cfg(8'b101, 3, 0, 0, 0, 1); bits(32'b10101101, 8);
    abort = 1; tick();
    cfg(8'b11, 2, 1, 2, 0, 0); pulse_start(); bits(32'b111, 3); tick();
    done_ack = 1; tick();
    cfg(8'b111, 3, 1, 0, 4, 1); bits(32'b1101, 4);
    done_ack = 1; tick();
    cfg(8'b111, 3, 1, 1, 4, 1); bits(32'b0111, 4);
    done_ack = 1; tick();
    cfg(8'b1, 0, 1, 0, 0, 1); tick();
    done_ack = 1; tick();
    cfg(8'b1, 9, 1, 0, 0, 0); pulse_start(); tick();
    abort = 1; tick();
    cfg(8'b101, 3, 1, 0, 0, 1); bits(32'b10, 2);
    abort = 1; tick(); tick();
    cfg(8'b11, 2, 0, 0, 0, 1); bits(32'b1, 1);
    rst = 1; tick();
    pulse_start(); bits(32'b101, 3);
    abort = 1; tick();
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(0, 1) ? 0 : $urandom_range(9, 15))
                                             : 4'($urandom_range(1, $urandom_range(0, 1) ? 3 : 8));
      cfg_overlap = 1'($urandom);
      cfg_target = 8'($urandom_range(0, 3));
      cfg_window = $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(1, 20));
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 29) == 0);
      done_ack = ($urandom_range(0, 3) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      datain = 1'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
